vending_machine_multi: RTL and testbench

Parametrised successor to the single-product coin vending FSM. It accepts 10/20/50 coins into a saturating credit register and supports NUM_ITEMS products with per-item prices. On a valid selection it emits a one-cycle dispense pulse, then returns any remainder as a serial stream of change coins. A cancel request refunds the full credit the same way.

---
 rtl/vending_pkg.sv | 30 +++
 rtl/vm_change_unit.sv | 26 ++
 rtl/vending_machine_multi.sv | 176 +++++++++++++++++
 tb/tb_vending_machine_multi.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and helpers for the multi-item vending machine.
// Coin encodings, unit values, FSM state enum and coin value lookup.
package vending_pkg;

   localparam logic [1:0] COIN_10  = 2'b00;
   localparam logic [1:0] COIN_20  = 2'b01;
   localparam logic [1:0] COIN_50  = 2'b10;
   localparam logic [1:0] COIN_BAD = 2'b11;

   localparam logic [2:0] UNITS_10 = 3'd1;
   localparam logic [2:0] UNITS_20 = 3'd2;
   localparam logic [2:0] UNITS_50 = 3'd5;

   typedef enum logic [1:0] {
      IDLE,
      CREDIT,
      VEND,
      CHANGE
   } state_t;

   function automatic logic [2:0] coin_units(input logic [1:0] c);
      case (c)
         COIN_10: return UNITS_10;
         COIN_20: return UNITS_20;
         COIN_50: return UNITS_50;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/vm_change_unit.sv
// Greedy change selector: picks the largest coin that fits the credit.
// Pure combinational; the top registers its result.
module vm_change_unit
   import vending_pkg::*;
#(
   parameter int CREDIT_W = 4
)(
   input  logic [CREDIT_W-1:0] credit,
   output logic [1:0]          coin,
   output logic [2:0]          units
);

   // largest denomination not exceeding the remaining credit
   always_comb begin
      coin  = COIN_10;
      units = UNITS_10;
      if (credit >= CREDIT_W'(UNITS_50)) begin
         coin  = COIN_50;
         units = UNITS_50;
      end else if (credit >= CREDIT_W'(UNITS_20)) begin
         coin  = COIN_20;
         units = UNITS_20;
      end
   end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item coin vending FSM with greedy change return.
// Optional per-item stock counters when STOCK_TRACK_EN is defined.
module vending_machine_multi
   import vending_pkg::*;
#(
   parameter int NUM_ITEMS  = 4,
   parameter int SEL_W      = 2,
   parameter int CREDIT_W   = 4,
   parameter int MAX_CREDIT = 15,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_TABLE =
      {4'd10, 4'd7, 4'd5, 4'd4},
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 8
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 coin_valid,
   input  logic [1:0]           coin,
   input  logic                 sel_valid,
   input  logic [SEL_W-1:0]     sel,
   input  logic                 cancel,
   output logic                 dispense,
   output logic [SEL_W-1:0]     dispense_item,
   output logic                 change_valid,
   output logic [1:0]           change_coin,
   output logic                 coin_reject,
   output logic [CREDIT_W-1:0]  credit,
   output logic                 busy,
   output logic [NUM_ITEMS-1:0] sold_out
);

   state_t              state_q, state_n;
   logic [CREDIT_W-1:0] credit_n;
   logic                disp_n, rej_n, cv_n, busy_n;
   logic [SEL_W-1:0]    item_n;
   logic [1:0]          ccoin_n;
   logic [2:0]          cunits_q, cunits_n;

   logic [CREDIT_W-1:0] prices [NUM_ITEMS];
   logic [CREDIT_W-1:0] price;
   logic                sel_acc;
   logic [CREDIT_W:0]   sum;
   logic                coin_ok;
   logic [CREDIT_W-1:0] chg_src;
   logic [1:0]          unit_coin;
   logic [2:0]          unit_units;

   for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price
      assign prices[i] = PRICE_TABLE[i*CREDIT_W +: CREDIT_W];
   end

   assign price   = prices[sel];
   assign sel_acc = sel_valid && (int'(sel) < NUM_ITEMS) &&
                    (credit >= price) && !sold_out[sel];
   assign sum     = {1'b0, credit} + (CREDIT_W+1)'(coin_units(coin));
   assign coin_ok = (coin != COIN_BAD) &&
                    (sum <= (CREDIT_W+1)'(MAX_CREDIT));

   // credit left once the coin now on the output has been paid out
   assign chg_src = (state_q == CHANGE) ?
                    credit - CREDIT_W'(cunits_q) : credit;

   vm_change_unit #(.CREDIT_W(CREDIT_W)) u_change (
      .credit (chg_src),
      .coin   (unit_coin),
      .units  (unit_units)
   );

   // state and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         credit        <= '0;
         dispense      <= 1'b0;
         dispense_item <= '0;
         change_valid  <= 1'b0;
         change_coin   <= COIN_10;
         cunits_q      <= '0;
         coin_reject   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state_q       <= state_n;
         credit        <= credit_n;
         dispense      <= disp_n;
         dispense_item <= item_n;
         change_valid  <= cv_n;
         change_coin   <= ccoin_n;
         cunits_q      <= cunits_n;
         coin_reject   <= rej_n;
         busy          <= busy_n;
      end
   end

   // next state: cancel beats selection beats coin
   always_comb begin
      state_n  = state_q;
      credit_n = credit;
      disp_n   = 1'b0;
      item_n   = dispense_item;
      rej_n    = 1'b0;
      cv_n     = 1'b0;
      ccoin_n  = change_coin;
      cunits_n = cunits_q;
      unique case (state_q)
         IDLE: begin
            if (coin_valid) begin
               if (coin_ok) begin
                  credit_n = sum[CREDIT_W-1:0];
                  state_n  = CREDIT;
               end else begin
                  rej_n = 1'b1;
               end
            end
         end
         CREDIT: begin
            if (cancel) begin
               state_n = CHANGE;
               cv_n    = 1'b1;
               rej_n   = coin_valid;
            end else if (sel_acc) begin
               state_n  = VEND;
               credit_n = credit - price;
               disp_n   = 1'b1;
               item_n   = sel;
               rej_n    = coin_valid;
            end else if (coin_valid) begin
               if (coin_ok) credit_n = sum[CREDIT_W-1:0];
               else rej_n = 1'b1;
            end
         end
         VEND: begin
            rej_n = coin_valid;
            if (credit == '0) begin
               state_n = IDLE;
            end else begin
               state_n = CHANGE;
               cv_n    = 1'b1;
            end
         end
         CHANGE: begin
            rej_n    = coin_valid;
            credit_n = chg_src;
            if (chg_src == '0) state_n = IDLE;
            else cv_n = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      if (cv_n) begin
         ccoin_n  = unit_coin;
         cunits_n = unit_units;
      end
      busy_n = (state_n == VEND) || (state_n == CHANGE);
   end

`ifdef STOCK_TRACK_EN
   logic [STOCK_W-1:0] stock [NUM_ITEMS];

   // one unit leaves stock during each VEND cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_ITEMS; i++)
            stock[i] <= STOCK_W'(STOCK_INIT);
      end else if (state_q == VEND &&
                   stock[dispense_item] != '0) begin
         stock[dispense_item] <= stock[dispense_item] - 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_sold
      assign sold_out[i] = (stock[i] == '0);
   end
`else
   assign sold_out = '0;
`endif

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi.
// Covers vend, change, cancel, rejects, priorities and async reset.
module tb_vending_machine_multi;
   import vending_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       coin_valid;
   logic [1:0] coin;
   logic       sel_valid;
   logic [1:0] sel;
   logic       cancel;
   logic       dispense;
   logic [1:0] dispense_item;
   logic       change_valid;
   logic [1:0] change_coin;
   logic       coin_reject;
   logic [3:0] credit;
   logic       busy;
   logic [3:0] sold_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vending_machine_multi #(.STOCK_INIT(1)) dut (
      .clk           (clk),
      .reset         (reset),
      .coin_valid    (coin_valid),
      .coin          (coin),
      .sel_valid     (sel_valid),
      .sel           (sel),
      .cancel        (cancel),
      .dispense      (dispense),
      .dispense_item (dispense_item),
      .change_valid  (change_valid),
      .change_coin   (change_coin),
      .coin_reject   (coin_reject),
      .credit        (credit),
      .busy          (busy),
      .sold_out      (sold_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic cv, input logic [1:0] c,
                        input logic sv, input logic [1:0] s,
                        input logic cn);
      coin_valid = cv;
      coin       = c;
      sel_valid  = sv;
      sel        = s;
      cancel     = cn;
      tick();
      coin_valid = 1'b0;
      sel_valid  = 1'b0;
      cancel     = 1'b0;
   endtask

   task automatic put(input logic [1:0] c);
      drive(1'b1, c, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic pick(input logic [1:0] s);
      drive(1'b0, COIN_10, 1'b1, s, 1'b0);
   endtask

   task automatic look(input string tag, input logic d,
                       input logic [1:0] di, input logic cv,
                       input logic [1:0] cc, input logic rj,
                       input logic [3:0] cr, input logic b);
      chk({tag, ".dispense"}, dispense, d);
      if (d) chk({tag, ".item"}, dispense_item, di);
      chk({tag, ".change_valid"}, change_valid, cv);
      if (cv) chk({tag, ".change_coin"}, change_coin, cc);
      chk({tag, ".reject"}, coin_reject, rj);
      chk({tag, ".credit"}, credit, cr);
      chk({tag, ".busy"}, busy, b);
   endtask

   initial begin
      reset      = 1'b1;
      coin_valid = 1'b0;
      coin       = COIN_10;
      sel_valid  = 1'b0;
      sel        = 2'd0;
      cancel     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      look("rst", 0, 0, 0, 0, 0, 0, 0);
      chk("rst.item", dispense_item, 0);
      chk("rst.sold", sold_out, 0);
      reset = 1'b0;
      tick();

      // exact payment: 10+20+10 for item0 (40)
      put(COIN_10); look("t1c1", 0, 0, 0, 0, 0, 1, 0);
      put(COIN_20); look("t1c2", 0, 0, 0, 0, 0, 3, 0);
      put(COIN_10); look("t1c3", 0, 0, 0, 0, 0, 4, 0);
      pick(2'd0);   look("t1v",  1, 0, 0, 0, 0, 0, 1);
      tick();       look("t1e",  0, 0, 0, 0, 0, 0, 0);

      // 50 for item0 leaves one 10 change
      put(COIN_50); look("t2c",  0, 0, 0, 0, 0, 5, 0);
      pick(2'd0);   look("t2v",  1, 0, 0, 0, 0, 1, 1);
      tick();       look("t2ch", 0, 0, 1, COIN_10, 0, 1, 1);
      tick();       look("t2e",  0, 0, 0, 0, 0, 0, 0);

      // 20+50 for item1 (50) leaves one 20 change
      put(COIN_20); look("t3c1", 0, 0, 0, 0, 0, 2, 0);
      put(COIN_50); look("t3c2", 0, 0, 0, 0, 0, 7, 0);
      pick(2'd1);   look("t3v",  1, 1, 0, 0, 0, 2, 1);
      tick();       look("t3ch", 0, 0, 1, COIN_20, 0, 2, 1);
      tick();       look("t3e",  0, 0, 0, 0, 0, 0, 0);

      // cancel 80 refunds 50,20,10
      put(COIN_10); put(COIN_20); put(COIN_50);
      look("t4c", 0, 0, 0, 0, 0, 8, 0);
      drive(1'b0, COIN_10, 1'b0, 2'd0, 1'b1);
      look("t4r1", 0, 0, 1, COIN_50, 0, 8, 1);
      tick(); look("t4r2", 0, 0, 1, COIN_20, 0, 3, 1);
      tick(); look("t4r3", 0, 0, 1, COIN_10, 0, 1, 1);
      tick(); look("t4e",  0, 0, 0, 0, 0, 0, 0);

      // saturation at 150 and the invalid coin code
      put(COIN_50); put(COIN_50); put(COIN_50);
      look("t5full", 0, 0, 0, 0, 0, 15, 0);
      put(COIN_10);  look("t5ovf",  0, 0, 0, 0, 1, 15, 0);
      tick();        look("t5idle", 0, 0, 0, 0, 0, 15, 0);
      put(COIN_BAD); look("t5bad",  0, 0, 0, 0, 1, 15, 0);
      pick(2'd3);    look("t5v",    1, 3, 0, 0, 0, 5, 1);
      tick();        look("t5ch",   0, 0, 1, COIN_50, 0, 5, 1);
      tick();        look("t5e",    0, 0, 0, 0, 0, 0, 0);

      // selection in IDLE is ignored
      pick(2'd0); look("t6idle", 0, 0, 0, 0, 0, 0, 0);

      // cancel beats sel; the coin alongside is rejected
      put(COIN_50);
      drive(1'b1, COIN_10, 1'b1, 2'd0, 1'b1);
      look("t6cx", 0, 0, 1, COIN_50, 1, 5, 1);
      tick(); look("t6cxe", 0, 0, 0, 0, 0, 0, 0);

      // accepted sel rejects the coin alongside
      put(COIN_50);
      drive(1'b1, COIN_10, 1'b1, 2'd0, 1'b0);
      look("t6sx", 1, 0, 0, 0, 1, 1, 1);
      tick(); look("t6sxc", 0, 0, 1, COIN_10, 0, 1, 1);
      tick(); look("t6sxe", 0, 0, 0, 0, 0, 0, 0);

      // unaffordable sel is dropped, coin still taken
      put(COIN_10);
      drive(1'b1, COIN_20, 1'b1, 2'd3, 1'b0);
      look("t6rs", 0, 0, 0, 0, 0, 3, 0);

      // reset mid-CHANGE with credit 3 clears at once
      drive(1'b0, COIN_10, 1'b0, 2'd0, 1'b1);
      look("t7ch", 0, 0, 1, COIN_20, 0, 3, 1);
      reset = 1'b1;
      #1;
      look("t7rst", 0, 0, 0, 0, 0, 0, 0);
      chk("t7rst.coin", change_coin, 0);
      chk("t7rst.item", dispense_item, 0);
      #1;
      reset = 1'b0;
      tick(); look("t7post", 0, 0, 0, 0, 0, 0, 0);

`ifdef STOCK_TRACK_EN
      // single unit of item0: vend it, then item0 is refused
      put(COIN_50);
      pick(2'd0);
      look("t8v", 1, 0, 0, 0, 0, 1, 1);
      tick();
      chk("t8sold", sold_out, 4'b0001);
      tick();
      put(COIN_50);
      pick(2'd0);
      look("t8ign", 0, 0, 0, 0, 0, 5, 0);
      chk("t8sold2", sold_out, 4'b0001);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
